load_store_unit: RTL and testbench

Sequencer between the pipeline's memory stage and the data RAM. Accepts one load or store request at a time over a valid/ready handshake and drives the RAM's separate read/write address ports. It absorbs the RAM's one-cycle registered read latency and returns exactly one response per request over a second valid/ready handshake. Optionally, sub-word accesses are built on the word-only RAM using read-modify-write and load extraction.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/load_store_unit_lane_align.sv | 52 +++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD; 3 behaves as word)
//   - FSM state enum lsu_state_t
//   - misaligned(): alignment rule for a given size and byte offset
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WRITE = 2'd2,
    RESP      = 2'd3
  } lsu_state_t;

  // Bytes never misalign, halves need an even address, words (and size 3)
  // need a word-aligned address.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = off[0];
      default:   misaligned = (off != 2'd0);
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: combinational lane logic for sub-word accesses on a
// 32-bit word RAM. Only instantiated when LSU_SUBWORD_EN is defined.
// Ports:
//   old_word  in  32  current RAM word
//   wdata     in  32  store data, sub-word value in the low bits
//   size      in  2   access size encoding
//   offset    in  2   byte offset within the word (already known aligned)
//   is_signed in  1   sign-extend sub-word loads
//   merged    out 32  old_word with the target lanes replaced by wdata
//   extracted out 32  selected lanes of old_word, zero/sign extended
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [4:0]  sh;
  logic [31:0] mask;
  logic [31:0] shifted;

  // Little-endian: byte k lives at bit 8k, so the lane shift is offset*8.
  // Halves are even-aligned, so the same shift lands on bytes {2h+1,2h}.
  assign sh      = {offset, 3'b000};
  assign shifted = old_word >> sh;

  always_comb begin
    mask      = 32'hFFFF_FFFF;
    extracted = old_word;
    case (size)
      SIZE_BYTE: begin
        mask      = 32'h0000_00FF << sh;
        extracted = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        mask      = 32'h0000_FFFF << sh;
        extracted = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        mask      = 32'hFFFF_FFFF;
        extracted = old_word;
      end
    endcase
    merged = (old_word & ~mask) | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one load/store at a time between the memory
// stage and a word RAM with a one-cycle registered read.
// Optional feature macro: LSU_SUBWORD_EN (byte/half accesses via
// read-modify-write and load extraction). Undefined: word-only accesses.
// Ports:
//   clk, reset (async, active high)
//   req_valid/req_ready, req_write, req_addr (byte), req_size, req_signed,
//   req_wdata                    -- request channel
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err -- response channel
//   ram_read_addr, ram_write_addr, ram_write, ram_in, ram_out -- RAM side
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds its payload while valid is high and not ready.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_in,
  input  logic [DATA_WIDTH-1:0] ram_out
);
  import lsu_pkg::*;

  lsu_state_t state, state_next;

  logic [ADDR_WIDTH-1:0] a_idx;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [1:0]            size_eff;
  logic                  accept;
  logic                  mis;
  logic                  is_word;
  logic [DATA_WIDTH-1:0] load_val;

`ifdef LSU_SUBWORD_EN
  logic [1:0]            a_off;
  logic [1:0]            a_size;
  logic                  a_signed;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] merge_val;

  assign size_eff = req_size;

  lsu_lane_align u_lane (
    .old_word  (ram_out),
    .wdata     (a_wdata),
    .size      (a_size),
    .offset    (a_off),
    .is_signed (a_signed),
    .merged    (merge_val),
    .extracted (load_val)
  );
`else
  // Word-only build: size and sign are ignored, every access is a word.
  logic unused_subword;
  assign unused_subword = ^{req_size, req_signed};
  assign size_eff       = SIZE_WORD;
  assign load_val       = ram_out;
`endif

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign mis       = misaligned(size_eff, req_addr[1:0]);
  assign is_word   = size_eff[1];
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // In IDLE the RAM sees the live request address so a load's read is
  // launched on the accepting edge; afterwards the captured index is used.
  assign ram_read_addr  = (state == IDLE) ? req_addr[ADDR_WIDTH+1:2] : a_idx;
  assign ram_write_addr = (state == IDLE) ? req_addr[ADDR_WIDTH+1:2] : a_idx;

  always_comb begin
    state_next = state;
    ram_write  = 1'b0;
    ram_in     = req_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mis) begin
            state_next = RESP;
          end else if (req_write) begin
            if (is_word) begin
              ram_write  = 1'b1;
              state_next = RESP;
            end else begin
`ifdef LSU_SUBWORD_EN
              state_next = RMW_WRITE;
`else
              state_next = RESP;
`endif
            end
          end else begin
            state_next = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: state_next = RESP;
`ifdef LSU_SUBWORD_EN
      RMW_WRITE: begin
        // ram_out holds the old word read at the accepting edge.
        ram_write  = 1'b1;
        ram_in     = merge_val;
        state_next = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A reset landing mid-access must not leave a partial write behind.
    if (reset) ram_write = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a_idx   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef LSU_SUBWORD_EN
      a_off    <= 2'd0;
      a_size   <= SIZE_WORD;
      a_signed <= 1'b0;
      a_wdata  <= '0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        a_idx   <= req_addr[ADDR_WIDTH+1:2];
        rdata_q <= '0;
        err_q   <= mis;
`ifdef LSU_SUBWORD_EN
        a_off    <= req_addr[1:0];
        a_size   <= req_size;
        a_signed <= req_signed;
        a_wdata  <= req_wdata;
`endif
      end
      if (state == LOAD_WAIT) rdata_q <= load_val;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_write, req_signed;
  logic [AW+1:0] req_addr;
  logic [1:0]    req_size;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_read_addr, ram_write_addr;
  logic          ram_write;
  logic [DW-1:0] ram_in, ram_out;

  load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
    .ram_write(ram_write), .ram_in(ram_in), .ram_out(ram_out)
  );

  // ---------------- RAM environment (registered read) ----------------
  logic [DW-1:0] mem [0:15];
  logic          pre_we;
  logic [AW-1:0] pre_idx;
  logic [DW-1:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (ram_write) mem[ram_write_addr] <= ram_in;
    ram_out <= mem[ram_read_addr];
  end

  int wr_pulses = 0;
  always @(negedge clk) if (ram_write) wr_pulses++;

  // ---------------- scoreboard ----------------
  logic [31:0] ref_mem [0:15];
  logic [DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int eff_bytes(input logic [1:0] sz);
    if (!SUBWORD) return 4;
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic accept_req(input logic w, input logic [5:0] a, input logic [1:0] sz,
                            input logic sg, input logic [31:0] wd);
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
    req_signed = sg; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [5:0] a, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, input int hold);
    int eb, off, idx, lat, w0, exp_lat, exp_wr;
    logic mis;
    longint unsigned m, v, word;
    logic [31:0] exp_d;
    eb = eff_bytes(sz); off = int'(a[1:0]); idx = int'(a[5:2]);
    mis = (off % eb) != 0;
    m = (64'd1 << (8 * eb)) - 64'd1;
    word = 64'(ref_mem[idx]);
    exp_d = 32'd0; exp_wr = 0;
    if (mis) exp_lat = 1;
    else if (w) begin
      exp_wr = 1;
      exp_lat = (eb == 4) ? 1 : 2;
      ref_mem[idx] = 32'((word & ~(m << (8 * off))) | ((64'(wd) & m) << (8 * off)));
    end else begin
      exp_lat = 2;
      v = (word >> (8 * off)) & m;
      if (SUBWORD && sg && eb < 4 && ((v >> (8 * eb - 1)) & 64'd1) != 0) v = v | ~m;
      exp_d = v[31:0];
    end
    exp_q.push_back(exp_d);
    w0 = wr_pulses;
    accept_req(w, a, sz, sg, wd);
    lat = 1;
    while (!rsp_valid && lat < 8) begin @(posedge clk); #1; lat++; end
    check("latency", lat, exp_lat);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, mis});
    check("rsp_rdata", rsp_rdata, exp_q.pop_front());
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_d);
      check("hold_err", {31'd0, rsp_err}, {31'd0, mis});
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_done", {31'd0, rsp_valid}, 32'd0);
    check("ready_back", {31'd0, req_ready}, 32'd1);
    check("wr_pulses", wr_pulses - w0, exp_wr);
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  // Reset lands one cycle after acceptance (LOAD_WAIT or RMW_WRITE).
  task automatic reset_mid(input logic w, input logic [5:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
    int w0, idx;
    idx = int'(a[5:2]);
    w0 = wr_pulses;
    accept_req(w, a, sz, 1'b0, wd);
    reset = 1'b1;
    #2;
    check("rst_ramwr", {31'd0, ram_write}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_rspv", {31'd0, rsp_valid}, 32'd0);
    check("rst_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    check("rst_norsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_nowr", wr_pulses - w0, 0);
    check("rst_mem", mem[idx], ref_mem[idx]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = 2'd2; req_signed = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;

    for (int i = 0; i < 16; i++) begin
      pre_we = 1'b1; pre_idx = 4'(i);
      pre_data = (i == 3) ? 32'h8899AABB : $urandom;
      ref_mem[i] = pre_data;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    // Reset state, with a word store offered while reset is high.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h04; req_wdata = 32'hDEADBEEF;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_ram_write", {31'd0, ram_write}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_mem", mem[1], ref_mem[1]);

    // Directed cases around word 3 = 8899AABB.
    do_req(1'b0, 6'h0C, 2'd2, 1'b0, 32'd0, 0);
    do_req(1'b0, 6'h0D, 2'd0, 1'b1, 32'd0, 0);
    do_req(1'b0, 6'h0E, 2'd1, 1'b0, 32'd0, 0);
    do_req(1'b1, 6'h0E, 2'd0, 1'b0, 32'h55, 0);
`ifdef LSU_SUBWORD_EN
    check("byte_store_word3", mem[3], 32'h8855AABB);
`else
    check("word3_untouched", mem[3], 32'h8899AABB);
`endif
    do_req(1'b0, 6'h0D, 2'd2, 1'b0, 32'd0, 0);
    do_req(1'b1, 6'h0D, 2'd2, 1'b0, 32'h12345678, 0);
    do_req(1'b0, 6'h0C, 2'd2, 1'b0, 32'd0, 5);
    do_req(1'b1, 6'h20, 2'd3, 1'b0, 32'hCAFEF00D, 1);
    do_req(1'b0, 6'h20, 2'd3, 1'b1, 32'd0, 0);

    reset_mid(1'b0, 6'h0C, 2'd2, 32'd0);
`ifdef LSU_SUBWORD_EN
    reset_mid(1'b1, 6'h0E, 2'd0, 32'h11);
`endif

    // Randomized traffic.
    for (int t = 0; t < 120; t++) begin
      logic [5:0] a;
      logic [1:0] sz;
      a = 6'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz != 2'd0) a[1:0] = 2'd0;
      end
      do_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
             $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
